// File: rtl/alu_seq_pkg.sv
// Shared types and opcode constants for the ALU command sequencer.
package alu_seq_pkg;

   localparam int PKG_DATA_W = 32;
   localparam int PKG_TAG_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam logic [3:0] OP_ARITH = 4'b0000;
   localparam logic [3:0] OP_LOGIC = 4'b0001;
   localparam logic [3:0] OP_CMP   = 4'b0010;
   localparam logic [3:0] OP_SHIFT = 4'b0011;
   localparam logic [3:0] OP_CLMUL = 4'b1001;
   localparam logic [3:0] OP_CRC   = 4'b1010;

   typedef struct packed {
      logic [3:0]            opcode;
      logic [2:0]            funct;
      logic [PKG_DATA_W-1:0] a;
      logic [PKG_DATA_W-1:0] b;
      logic [PKG_TAG_W-1:0]  tag;
   } req_t;

endpackage

// File: rtl/alu_seq_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit for full/empty.
module alu_seq_fifo
   import alu_seq_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = req_t
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  entry_t                   wdata,
   input  logic                     pop,
   output entry_t                   rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   entry_t         mem_q [DEPTH];
   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic           do_push, do_pop;

   always_comb begin
      level    = wr_ptr_q - rd_ptr_q;
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
      // Storage is written at the clock edge, so a fresh entry is never visible the same cycle.
      rdata    = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues queued ALU requests one at a time and returns tagged results.
// Optional WAIT watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 4,
   parameter int TAG_W       = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [3:0]                req_opcode,
   input  logic [2:0]                req_funct,
   input  logic [DATA_W-1:0]         req_a,
   input  logic [DATA_W-1:0]         req_b,
   input  logic [TAG_W-1:0]          req_tag,
   output logic                      alu_valid_i,
   output logic [3:0]                alu_opcode,
   output logic [2:0]                alu_funct,
   output logic [DATA_W-1:0]         alu_a,
   output logic [DATA_W-1:0]         alu_b,
   input  logic [DATA_W-1:0]         alu_o,
   input  logic                      alu_valid_o,
   input  logic                      alu_overflow,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_overflow,
   output logic [TAG_W-1:0]          rsp_tag,
   output logic                      rsp_timeout,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic                      err_spurious
);

   // Same layout as req_t, but sized from this instance's parameters.
   typedef struct packed {
      logic [3:0]        opcode;
      logic [2:0]        funct;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [TAG_W-1:0]  tag;
   } req_w_t;

   req_w_t               wr_entry, head;
   logic                 fifo_full, fifo_empty, fifo_pop, fifo_push;

   state_e               state_q, state_d;
   logic                 alu_valid_i_q, alu_valid_i_d;
   logic [3:0]           alu_opcode_q, alu_opcode_d;
   logic [2:0]           alu_funct_q, alu_funct_d;
   logic [DATA_W-1:0]    alu_a_q, alu_a_d;
   logic [DATA_W-1:0]    alu_b_q, alu_b_d;
   logic [TAG_W-1:0]     tag_q, tag_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
   logic                 rsp_overflow_q, rsp_overflow_d;
   logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;
   logic                 err_spurious_q, err_spurious_d;

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int               TMO_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);
   logic [TMO_W-1:0]            tmo_cnt_q, tmo_cnt_d;
   logic                        rsp_timeout_q, rsp_timeout_d;
`endif

   assign req_ready = !fifo_full && !rst;
   assign fifo_push = req_valid && req_ready;

   always_comb begin
      wr_entry        = '0;
      wr_entry.opcode = req_opcode;
      wr_entry.funct  = req_funct;
      wr_entry.a      = req_a;
      wr_entry.b      = req_b;
      wr_entry.tag    = req_tag;
   end

   alu_seq_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (req_w_t)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (wr_entry),
      .pop   (fifo_pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_comb begin
      state_d        = state_q;
      fifo_pop       = 1'b0;
      alu_valid_i_d  = 1'b0;
      alu_opcode_d   = alu_opcode_q;
      alu_funct_d    = alu_funct_q;
      alu_a_d        = alu_a_q;
      alu_b_d        = alu_b_q;
      tag_d          = tag_q;
      rsp_valid_d    = rsp_valid_q;
      rsp_data_d     = rsp_data_q;
      rsp_overflow_d = rsp_overflow_q;
      rsp_tag_d      = rsp_tag_q;
      // A result strobe is only legitimate while a request is in flight.
      err_spurious_d = err_spurious_q || (alu_valid_o && (state_q != WAIT));
`ifdef ALU_SEQ_TIMEOUT_EN
      tmo_cnt_d      = tmo_cnt_q;
      rsp_timeout_d  = rsp_timeout_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop      = 1'b1;
               alu_opcode_d  = head.opcode;
               alu_funct_d   = head.funct;
               alu_a_d       = head.a;
               alu_b_d       = head.b;
               tag_d         = head.tag;
               alu_valid_i_d = 1'b1;
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
`ifdef ALU_SEQ_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
         WAIT: begin
            if (alu_valid_o) begin
               rsp_valid_d    = 1'b1;
               rsp_data_d     = alu_o;
               rsp_overflow_d = alu_overflow;
               rsp_tag_d      = tag_q;
               state_d        = RESP;
`ifdef ALU_SEQ_TIMEOUT_EN
               rsp_timeout_d  = 1'b0;
`endif
            end
`ifdef ALU_SEQ_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LIMIT) begin
               rsp_valid_d    = 1'b1;
               rsp_data_d     = '0;
               rsp_overflow_d = 1'b0;
               rsp_tag_d      = tag_q;
               rsp_timeout_d  = 1'b1;
               state_d        = RESP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
`endif
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         alu_valid_i_q  <= 1'b0;
         alu_opcode_q   <= '0;
         alu_funct_q    <= '0;
         alu_a_q        <= '0;
         alu_b_q        <= '0;
         tag_q          <= '0;
         rsp_valid_q    <= 1'b0;
         rsp_data_q     <= '0;
         rsp_overflow_q <= 1'b0;
         rsp_tag_q      <= '0;
         err_spurious_q <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
         tmo_cnt_q      <= '0;
         rsp_timeout_q  <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         alu_valid_i_q  <= alu_valid_i_d;
         alu_opcode_q   <= alu_opcode_d;
         alu_funct_q    <= alu_funct_d;
         alu_a_q        <= alu_a_d;
         alu_b_q        <= alu_b_d;
         tag_q          <= tag_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_data_q     <= rsp_data_d;
         rsp_overflow_q <= rsp_overflow_d;
         rsp_tag_q      <= rsp_tag_d;
         err_spurious_q <= err_spurious_d;
`ifdef ALU_SEQ_TIMEOUT_EN
         tmo_cnt_q      <= tmo_cnt_d;
         rsp_timeout_q  <= rsp_timeout_d;
`endif
      end
   end

   assign alu_valid_i  = alu_valid_i_q;
   assign alu_opcode   = alu_opcode_q;
   assign alu_funct    = alu_funct_q;
   assign alu_a        = alu_a_q;
   assign alu_b        = alu_b_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_overflow = rsp_overflow_q;
   assign rsp_tag      = rsp_tag_q;
   assign err_spurious = err_spurious_q;
`ifdef ALU_SEQ_TIMEOUT_EN
   assign rsp_timeout  = rsp_timeout_q;
`else
   assign rsp_timeout  = 1'b0;
`endif

endmodule
